player_ctrl: RTL and testbench

Sequences the player cannon from debounced button signals. Consumes the held `left`/`right` levels and the one-cycle `shoot` pulse produced by the input debouncer. Steps the cannon's x position once per frame tick. Arbitrates the single on-screen player bullet through a req/ack handshake with the bullet unit, holds one pending shot, and enforces a per-frame cooldown between shots.

---
 rtl/game_pkg.sv | 18 +
 rtl/player_ctrl_if.sv | 12 +
 rtl/tick_counter.sv | 29 ++
 rtl/player_ctrl.sv | 121 ++++++++++++
 tb/tb_player_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game constants and the cannon fire-state encoding.
// The sprite renderer and the bullet unit use the same screen geometry.
package game_pkg;

    localparam int SCREEN_W       = 640;
    localparam int CANNON_W       = 32;
    localparam int X_W            = 10;
    localparam int PLAYER_X_MIN   = 0;
    localparam int PLAYER_X_MAX   = SCREEN_W - CANNON_W;
    localparam int PLAYER_X_START = (PLAYER_X_MIN + PLAYER_X_MAX) / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        COOL = 2'd2
    } fire_state_t;

endpackage

// File: rtl/player_ctrl_if.sv
// Bullet spawn handshake between the player controller and the bullet unit.
interface player_ctrl_if;
    import game_pkg::*;

    logic           fire_req;
    logic [X_W-1:0] fire_x;
    logic           fire_ack;
    logic           bullet_active;

    modport master (output fire_req, output fire_x, input fire_ack, input bullet_active);
    modport slave  (input fire_req, input fire_x, output fire_ack, output bullet_active);
endinterface

// File: rtl/tick_counter.sv
// Loadable down-counter that steps on a tick enable and flags zero.
// Load wins over a same-cycle tick; the count holds at zero.
module tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // Down-count on enable, reload on request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/player_ctrl.sv
// Player cannon controller: per-frame movement with edge saturation and a
// req/ack fire sequencer with one pending shot and a frame-tick cooldown.
module player_ctrl
    import game_pkg::*;
#(
    parameter int X_MIN    = PLAYER_X_MIN,
    parameter int X_MAX    = PLAYER_X_MAX,
    parameter int X_START  = PLAYER_X_START,
    parameter int STEP     = 2,
    parameter int GUN_OFS  = 15,
    parameter int COOLDOWN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             game_en,
    input  logic             left,
    input  logic             right,
    input  logic             shoot,
    player_ctrl_if.master    fire_bus,
    output logic [X_W-1:0]   player_x,
    output logic             busy
);

    localparam int CNT_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    // Compare thresholds are formed before the step so the 10-bit
    // add/subtract can never wrap past either screen edge.
    localparam logic [X_W-1:0] LO_LIM  = X_W'(X_MIN + STEP);
    localparam logic [X_W-1:0] HI_LIM  = X_W'(X_MAX - STEP);
    localparam logic [X_W-1:0] X_LO    = X_W'(X_MIN);
    localparam logic [X_W-1:0] X_HI    = X_W'(X_MAX);
    localparam logic [X_W-1:0] X_RST   = X_W'(X_START);
    localparam logic [X_W-1:0] STEP_V  = X_W'(STEP);
    localparam logic [X_W-1:0] OFS_V   = X_W'(GUN_OFS);

    fire_state_t state;
    logic        pending;
    logic        cool_load;
    logic        cool_zero;

    // Cooldown is loaded as the ack is accepted; a tick in that same cycle is lost
    assign cool_load = (state == REQ) && fire_bus.fire_ack;

    tick_counter #(
        .W (CNT_W)
    ) u_cool (
        .clk      (clk),
        .rst      (rst),
        .load     (cool_load),
        .load_val (CNT_W'(COOLDOWN)),
        .en       (tick),
        .zero     (cool_zero)
    );

    // Cannon movement, one step per running frame tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            player_x <= X_RST;
        end else if (tick && game_en) begin
            if (left && !right) begin
                player_x <= (player_x < LO_LIM) ? X_LO : player_x - STEP_V;
            end else if (right && !left) begin
                player_x <= (player_x > HI_LIM) ? X_HI : player_x + STEP_V;
            end
        end
    end

    // Fire sequencer with registered req/x/busy and a single pending shot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            pending           <= 1'b0;
            busy              <= 1'b0;
            fire_bus.fire_req <= 1'b0;
            fire_bus.fire_x   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((shoot || pending) && game_en && !fire_bus.bullet_active) begin
                        state             <= REQ;
                        busy              <= 1'b1;
                        fire_bus.fire_req <= 1'b1;
                        fire_bus.fire_x   <= player_x + OFS_V;
                        pending           <= 1'b0;
                    end else if (shoot) begin
                        pending <= 1'b1;
                    end
                end
                REQ: begin
                    if (shoot) begin
                        pending <= 1'b1;
                    end
                    if (fire_bus.fire_ack) begin
                        state             <= COOL;
                        fire_bus.fire_req <= 1'b0;
                    end
                end
                COOL: begin
                    if (shoot) begin
                        pending <= 1'b1;
                    end
                    if (cool_zero) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state             <= IDLE;
                    busy              <= 1'b0;
                    fire_bus.fire_req <= 1'b0;
                end
            endcase
            // A stopped game discards any queued shot
            if (!game_en) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl against a cycle-level behavioural model.
module tb_player_ctrl;
    import game_pkg::*;

    localparam int XMIN = 0;
    localparam int XMAX = 608;
    localparam int XST  = 304;
    localparam int STP  = 2;
    localparam int OFS  = 15;
    localparam int CD   = 8;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       game_en;
    logic       left;
    logic       right;
    logic       shoot;
    logic [9:0] player_x;
    logic       busy;

    player_ctrl_if bus ();

    player_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .game_en  (game_en),
        .left     (left),
        .right    (right),
        .shoot    (shoot),
        .fire_bus (bus),
        .player_x (player_x),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: position as a plain integer, cooldown as ticks seen since ack
    int m_x;
    bit m_req;
    int m_fx;
    bit m_busy;
    bit m_pend;
    int m_since;

    task automatic model_reset();
        m_x = XST; m_req = 0; m_fx = 0; m_busy = 0; m_pend = 0; m_since = 0;
    endtask

    task automatic model_step();
        // Firing decisions use the position from before this edge
        if (!m_busy) begin
            if ((shoot || m_pend) && game_en && !bus.bullet_active) begin
                m_req = 1; m_busy = 1; m_fx = m_x + OFS; m_pend = 0;
            end else if (shoot) begin
                m_pend = 1;
            end
        end else if (m_req) begin
            if (shoot) m_pend = 1;
            if (bus.fire_ack) begin
                m_req = 0; m_since = 0;
            end
        end else begin
            if (shoot) m_pend = 1;
            if (m_since >= CD) m_busy = 0;
            else if (tick) m_since++;
        end
        if (!game_en) m_pend = 0;
        if (tick && game_en) begin
            if (left && !right) m_x = (m_x - STP < XMIN) ? XMIN : m_x - STP;
            else if (right && !left) m_x = (m_x + STP > XMAX) ? XMAX : m_x + STP;
        end
    endtask

    // One clock: the model advances at the edge, outputs are then read at the falling edge
    task automatic cycle();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        tick = 0; game_en = 1; left = 0; right = 0; shoot = 0;
        bus.fire_ack = 0; bus.bullet_active = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 0;
        model_reset();
        cycle();
        cycle();
        rst = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (player_x !== 10'd304) begin n_fail++; $display("FAIL reset_x: got %0d expected 304", player_x); end
        n_tests++;
        if (bus.fire_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.fire_req); end
        n_tests++;
        if (bus.fire_x !== 10'd0) begin n_fail++; $display("FAIL reset_fx: got %0d expected 0", bus.fire_x); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        $display("[TB] test_reset x=%0d req=%b busy=%b", player_x, bus.fire_req, busy);
    endtask

    task automatic test_move();
        do_reset();
        right = 1;
        for (int i = 0; i < 400; i++) begin
            tick = 1; cycle(); tick = 0; cycle();
            n_tests++;
            if (player_x !== 10'(m_x)) begin n_fail++; $display("FAIL move_right: tick %0d got %0d expected %0d", i, player_x, m_x); end
        end
        n_tests++;
        if (player_x !== 10'd608) begin n_fail++; $display("FAIL right_sat: got %0d expected 608", player_x); end
        right = 0; left = 1;
        for (int i = 0; i < 400; i++) begin
            tick = 1; cycle(); tick = 0; cycle();
            n_tests++;
            if (player_x !== 10'(m_x)) begin n_fail++; $display("FAIL move_left: tick %0d got %0d expected %0d", i, player_x, m_x); end
        end
        n_tests++;
        if (player_x !== 10'd0) begin n_fail++; $display("FAIL left_sat: got %0d expected 0", player_x); end
        left = 0;
        $display("[TB] test_move final x=%0d", player_x);
    endtask

    task automatic test_both();
        do_reset();
        left = 1; right = 1;
        for (int i = 0; i < 10; i++) begin
            tick = 1; cycle(); tick = 0; cycle();
        end
        n_tests++;
        if (player_x !== 10'd304) begin n_fail++; $display("FAIL both_held: got %0d expected 304", player_x); end
        left = 0; right = 0;
        $display("[TB] test_both x=%0d", player_x);
    endtask

    task automatic test_shot_timing();
        do_reset();
        repeat (8) cycle();
        shoot = 1; cycle(); shoot = 0;
        n_tests++;
        if (bus.fire_req !== 1'b1) begin n_fail++; $display("FAIL shot_req_rise: got %b expected 1", bus.fire_req); end
        n_tests++;
        if (bus.fire_x !== 10'd319) begin n_fail++; $display("FAIL shot_fire_x: got %0d expected 319", bus.fire_x); end
        cycle();
        n_tests++;
        if (bus.fire_req !== 1'b1) begin n_fail++; $display("FAIL shot_req_hold: got %b expected 1", bus.fire_req); end
        // ack together with a tick: that tick must not shorten the cooldown
        bus.fire_ack = 1; tick = 1; cycle(); bus.fire_ack = 0; tick = 0;
        n_tests++;
        if (bus.fire_req !== 1'b0) begin n_fail++; $display("FAIL shot_req_fall: got %b expected 0", bus.fire_req); end
        for (int k = 0; k < CD; k++) begin
            n_tests++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL cool_busy: before tick %0d got %b expected 1", k, busy); end
            tick = 1; cycle(); tick = 0;
        end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL cool_busy_last: got %b expected 1", busy); end
        cycle();
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cool_done: got %b expected 0", busy); end
        $display("[TB] test_shot_timing busy=%b", busy);
    endtask

    task automatic test_pending();
        int reqs;
        bit prev;
        do_reset();
        shoot = 1; cycle(); shoot = 0;
        bus.fire_ack = 1; cycle(); bus.fire_ack = 0;
        reqs = 0; prev = bus.fire_req;
        for (int i = 0; i < 300; i++) begin
            tick = (i % 4 == 0); right = 1;
            shoot = (i == 3 || i == 6);
            bus.fire_ack = m_req;
            cycle();
            n_tests++;
            if (bus.fire_req !== m_req) begin n_fail++; $display("FAIL pend_req: cycle %0d got %b expected %b", i, bus.fire_req, m_req); end
            if (bus.fire_req && !prev) reqs++;
            if (bus.fire_req) begin
                n_tests++;
                if (bus.fire_x !== 10'(m_fx)) begin n_fail++; $display("FAIL pend_fire_x: got %0d expected %0d", bus.fire_x, m_fx); end
            end
            prev = bus.fire_req;
        end
        idle_inputs();
        n_tests++;
        if (reqs !== 1) begin n_fail++; $display("FAIL pend_count: got %0d expected 1", reqs); end
        $display("[TB] test_pending further requests=%0d", reqs);
    endtask

    task automatic test_bullet_active();
        do_reset();
        bus.bullet_active = 1;
        shoot = 1; cycle(); shoot = 0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            n_tests++;
            if (bus.fire_req !== 1'b0) begin n_fail++; $display("FAIL ba_hold: cycle %0d got %b expected 0", i, bus.fire_req); end
        end
        bus.bullet_active = 0;
        cycle();
        n_tests++;
        if (bus.fire_req !== 1'b1) begin n_fail++; $display("FAIL ba_release: got %b expected 1", bus.fire_req); end
        bus.fire_ack = 1; cycle(); bus.fire_ack = 0;
        $display("[TB] test_bullet_active req=%b", bus.fire_req);
    endtask

    task automatic test_reset_mid();
        do_reset();
        right = 1; tick = 1; cycle(); tick = 0; right = 0;
        shoot = 1; cycle(); shoot = 0;
        n_tests++;
        if (bus.fire_req !== 1'b1) begin n_fail++; $display("FAIL mid_pre_req: got %b expected 1", bus.fire_req); end
        #2 rst = 0;
        model_reset();
        #1;
        n_tests++;
        if (bus.fire_req !== 1'b0) begin n_fail++; $display("FAIL mid_req_drop: got %b expected 0", bus.fire_req); end
        n_tests++;
        if (player_x !== 10'd304) begin n_fail++; $display("FAIL mid_x: got %0d expected 304", player_x); end
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_tests++;
            if (bus.fire_req !== 1'b0) begin n_fail++; $display("FAIL mid_no_req: cycle %0d got %b expected 0", i, bus.fire_req); end
        end
        shoot = 1; cycle(); shoot = 0;
        n_tests++;
        if (bus.fire_req !== 1'b1) begin n_fail++; $display("FAIL mid_new_shot: got %b expected 1", bus.fire_req); end
        bus.fire_ack = 1; cycle(); bus.fire_ack = 0;
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick    = ($urandom_range(0, 3) == 0);
            game_en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) left  = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) right = $urandom_range(0, 1);
            shoot = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) bus.bullet_active = ~bus.bullet_active;
            bus.fire_ack = m_req && ($urandom_range(0, 2) == 0);
            cycle();
            n_tests++;
            if (player_x !== 10'(m_x)) begin n_fail++; $display("FAIL rnd_x: cycle %0d got %0d expected %0d", i, player_x, m_x); end
            n_tests++;
            if (bus.fire_req !== m_req) begin n_fail++; $display("FAIL rnd_req: cycle %0d got %b expected %b", i, bus.fire_req, m_req); end
            n_tests++;
            if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy: cycle %0d got %b expected %b", i, busy, m_busy); end
            if (m_req) begin
                n_tests++;
                if (bus.fire_x !== 10'(m_fx)) begin n_fail++; $display("FAIL rnd_fire_x: cycle %0d got %0d expected %0d", i, bus.fire_x, m_fx); end
            end
        end
        idle_inputs();
        $display("[TB] test_random x=%0d", player_x);
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_move();
        test_both();
        test_shot_timing();
        test_pending();
        test_bullet_active();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
